riscv_lsu_ctrl: RTL
===================

# riscv_lsu_ctrl

Load/store controller between the core's execute stage and the data-memory port. It takes the memory request, write flag and access size produced by the instruction decoder and sequences one memory transaction per instruction. It stalls the core until the response arrives, generates byte enables and write-data lanes, and aligns and extends load data. It also flags misaligned or unsupported accesses and aborts transactions whose response never arrives.

## Interface
- TIMEOUT, 256: maximum cycles spent in WAIT before the transaction is aborted; 0 disables the watchdog.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- core_req_i  input  1  memory instruction present; held stable while core_stall_req_o is 1.
- core_we_i  input  1  1 = store, 0 = load.
- core_size_i  input  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
- core_addr_i  input  32  byte address (ALU result).
- core_wd_i  input  32  store data (rs2).
- core_rd_o  output  32  aligned, extended load data; valid in the RESP cycle.
- core_stall_req_o  output  1  hold the pipeline.
- misalign_o  output  1  one-cycle pulse: misaligned or unsupported access; no memory request issued.
- bus_err_o  output  1  one-cycle pulse: watchdog abort.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  write enable.
- mem_be_o  output  4  byte enables.
- mem_addr_o  output  32  {core_addr_i[31:2], 2'b00}.
- mem_wd_o  output  32  lane-replicated store data.
- mem_rd_i  input  32  read word.
- mem_ready_i  input  1  response valid or write accepted; ignored outside WAIT.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, core_req_i=0: all control outputs are 0.
- IDLE, core_req_i=1, aligned, supported size:
  - mem_req_o=1 and core_stall_req_o=1 combinationally.
  - Capture size_q and off_q=addr[1:0].
  - Clear the watchdog counter.
  - Go to WAIT.
- IDLE, misaligned or unsupported size:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Unsupported: size ∉ {0,1,2,4,5}.
  - Assert misalign_o and hold core_stall_req_o=0 and mem_req_o=0. Stay in IDLE.
- WAIT:
  - mem_req_o=1 and core_stall_req_o=1.
  - On mem_ready_i=1: a load writes the extended data to rdata_q; a store leaves rdata_q unchanged. Go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT (if nonzero): pulse bus_err_o, clear stall, and go to IDLE.
- RESP: mem_req_o=0, core_stall_req_o=0, core_rd_o=rdata_q. core_req_i is ignored because it still belongs to the retiring instruction. Go to IDLE.
- core_req_i dropping in WAIT is a protocol violation. The transaction still completes normally.
- Byte enables: B/BU → 4'b0001<<off; H/HU → 4'b0011<<off; W → 4'b1111. mem_be_o=0 when mem_req_o=0.
- Store data lanes: B → {4{wd[7:0]}}; H → {2{wd[15:0]}}; W → wd.
- Load data: select the byte or half at off_q, then sign-extend (B, H) or zero-extend (BU, HU). W passes through.
- mem_we_o = core_we_i & mem_req_o.

## Timing
- While rst_i=1: state=IDLE, rdata_q=0, counter=0, and all outputs 0 in the same cycle (forced regardless of inputs). core_rd_o=0.
- Reset during WAIT aborts the transaction. A later mem_ready_i in IDLE is ignored.
- Minimum access is 3 cycles: T0 IDLE issue, T1 WAIT with ready, T2 RESP (stall low).
- Stall is high from T0 through the ready cycle.
- With ready after k WAIT cycles, the stall lasts k+1 cycles.
- Back-to-back memory instructions: the next request is seen in IDLE the cycle after RESP.
- Watchdog abort lands in IDLE after exactly TIMEOUT WAIT cycles without ready. bus_err_o is high in the last WAIT cycle.
- Counter width is $clog2(TIMEOUT+1).

## Structure
- riscv_pkg: LDST_* size constants already exist there. Add the lsu_state_t enum (IDLE, WAIT, RESP).
- Sub-module riscv_lsu_load_align: combinational; inputs off, size, word; output extended data. Reused by any future unaligned or AMO path.
- Everything else (FSM, counter, lane logic) lives in riscv_lsu_ctrl.

## Test plan
- LB, addr 0x103, mem_rd 0x80FF_1234, ready in the first WAIT cycle:
  - mem_be 4'b1000, addr 0x100.
  - Stall high 2 cycles; RESP core_rd=0xFFFF_FF80.
  - LBU instead: 0x0000_0080.
- SH, addr 0x202, wd 0x1234_ABCD, ready after 3 WAIT cycles: mem_we=1, be 4'b1100, wd 0xABCD_ABCD, stall 4 cycles, rdata_q unchanged.
- LW, addr 0x306: misalign_o pulse, no mem_req_o, stall 0. Same for size 3'd3 at an aligned address.
- TIMEOUT=4, LW with ready never asserted: bus_err_o in the 4th WAIT cycle, IDLE next; a late ready is ignored.
- rst_i pulsed in WAIT: all outputs 0 in that cycle, IDLE next. A subsequent LW at 0x0 with ready completes normally with the correct data.
- Two back-to-back LWs with immediate ready: 6 cycles total, mem_req_o low in each RESP cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: load/store size encodings and LSU state type.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic logic ldst_size_ok(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Combinational load alignment: picks the byte/half at the word offset and
// sign- or zero-extends it; full words pass through untouched.
module riscv_lsu_load_align
  import riscv_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store controller: issues one memory transaction per instruction, stalls
// the core until the response, aligns load data and aborts on watchdog expiry.
module riscv_lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

  lsu_state_t    state_q, state_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0] ld_data;
  logic [CW:0] cnt_inc;
  logic        access_ok, timeout_hit;
  logic        req, stall, misalign, bus_err;
  logic [2:0]  sel_size;
  logic [1:0]  sel_off;
  logic [3:0]  be;
  logic [31:0] lanes;

  riscv_lsu_load_align u_load_align (
    .off_i  (off_q),
    .size_i (size_q),
    .word_i (mem_rd_i),
    .data_o (ld_data)
  );

  assign access_ok = ldst_size_ok(core_size_i) &&
                     !(((core_size_i == LDST_H) || (core_size_i == LDST_HU)) && core_addr_i[0]) &&
                     !((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00));
  assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    off_d    = off_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    req      = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    sel_size = size_q;
    sel_off  = off_q;
    case (state_q)
      IDLE: begin
        sel_size = core_size_i;
        sel_off  = core_addr_i[1:0];
        if (core_req_i) begin
          if (access_ok) begin
            req     = 1'b1;
            stall   = 1'b1;
            size_d  = core_size_i;
            off_d   = core_addr_i[1:0];
            we_d    = core_we_i;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem_ready_i) begin
          if (!we_q) rdata_d = ld_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
          if (timeout_hit) begin
            bus_err = 1'b1;
            stall   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      // The instruction on core_req_i here is the one retiring, so it is not reissued.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      req      = 1'b0;
      stall    = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
    end
  end

  always_comb begin
    case (sel_size)
      LDST_B, LDST_BU: begin be = 4'b0001 << sel_off; lanes = {4{core_wd_i[7:0]}}; end
      LDST_H, LDST_HU: begin be = 4'b0011 << sel_off; lanes = {2{core_wd_i[15:0]}}; end
      default:         begin be = 4'b1111;            lanes = core_wd_i; end
    endcase
  end

  assign mem_req_o        = req;
  assign mem_we_o         = core_we_i & req;
  assign mem_be_o         = req ? be : 4'b0000;
  assign mem_addr_o       = req ? {core_addr_i[31:2], 2'b00} : 32'h0;
  assign mem_wd_o         = req ? lanes : 32'h0;
  assign core_stall_req_o = stall;
  assign misalign_o       = misalign;
  assign bus_err_o        = bus_err;
  assign core_rd_o        = rst_i ? 32'h0 : rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      size_q  <= LDST_B;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
